// File: rtl/mem_page_reader_if.sv
// Signal bundle between mem_page_reader, its paged BRAM read port and the
// downstream word consumer.
interface mem_page_reader_if #(
  parameter int RAM_WIDTH = 18,
  parameter int AW        = 10
);
  // Control: ap_start is honoured only while ap_idle; ap_done pulses once per page.
  logic                 ap_start;
  logic [2:0]           bx;
  logic [63:0]          nent_all;
  logic                 ap_idle;
  logic                 ap_done;

  // BRAM read port: one read per cycle with enb high; doutb returns READ_LATENCY cycles later.
  logic [AW-1:0]        addrb;
  logic                 enb;
  logic                 regceb;
  logic                 rstb;
  logic [RAM_WIDTH-1:0] doutb;

  // Stream: a word transfers in every cycle where dout_valid && dout_ready;
  // dout/dout_last hold while dout_valid is high and dout_ready is low.
  logic [RAM_WIDTH-1:0] dout;
  logic                 dout_valid;
  logic                 dout_ready;
  logic                 dout_last;

  logic [2:0]           dbg_state;

  modport master (
    input  ap_start, bx, nent_all, doutb, dout_ready,
    output ap_idle, ap_done, addrb, enb, regceb, rstb,
           dout, dout_valid, dout_last, dbg_state
  );

  modport slave (
    output ap_start, bx, nent_all, doutb, dout_ready,
    input  ap_idle, ap_done, addrb, enb, regceb, rstb,
           dout, dout_valid, dout_last, dbg_state
  );
endinterface

// File: rtl/mem_page_reader.sv
// Reads one page of the paged BRAM per start, hides the read latency behind a
// credit-limited FWFT buffer and streams the words out with a last flag.
module mem_page_reader #(
  parameter int RAM_WIDTH    = 18,
  parameter int RAM_DEPTH    = 1024,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  mem_page_reader_if.master bus
);
  localparam int AW         = $clog2(RAM_DEPTH);
  localparam int PAGE_DEPTH = RAM_DEPTH / 8;
  localparam int PW         = AW - 3;
  localparam int CW         = PW + 1;
  localparam int FW         = $clog2(FIFO_DEPTH);
  localparam int QW         = FW + 1;
  localparam int LW         = $clog2(READ_LATENCY + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LATCH = 3'd1,
    S_ISSUE = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                  state;
  logic [2:0]              page;
  logic [CW-1:0]           total;
  logic [CW-1:0]           issued;
  logic [CW-1:0]           pushed;
  logic [CW-1:0]           delivered;
  logic                    enb_q;
  logic [AW-1:0]           addrb_q;
  logic                    ap_idle_q;
  logic                    ap_done_q;
  logic [READ_LATENCY-1:0] tag_sr;

  logic [RAM_WIDTH-1:0]    fifo_data [FIFO_DEPTH];
  logic                    fifo_last [FIFO_DEPTH];
  logic [FW-1:0]           wr_ptr;
  logic [FW-1:0]           rd_ptr;
  logic [QW-1:0]           fifo_count;

  logic                    push;
  logic                    push_last;
  logic                    pop;
  logic                    fifo_empty;
  logic [READ_LATENCY-1:0] tag_next;
  logic [QW-1:0]           count_next;
  logic [LW-1:0]           inflight_next;
  logic                    room;
  logic [7:0]              nent;
  logic [CW-1:0]           total_c;

  // A read tag leaves the shift register in the cycle its data sits on doutb.
  if (READ_LATENCY == 1) begin : g_lat1
    assign tag_next = enb_q;
  end else begin : g_latn
    assign tag_next = {tag_sr[READ_LATENCY-2:0], enb_q};
  end

  assign push       = tag_sr[READ_LATENCY-1];
  assign push_last  = (pushed == total - 1'b1);
  assign fifo_empty = (fifo_count == '0);
  assign pop        = !fifo_empty && bus.dout_ready;
  assign count_next = fifo_count + QW'(push) - QW'(pop);
  assign nent       = bus.nent_all[{page, 3'b000} +: 8];

  // Credits are judged on the post-edge occupancy so the read being decided
  // now is the only one not yet counted.
  always_comb begin
    inflight_next = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight_next = inflight_next + LW'(tag_next[i]);
    end
    room = (32'(count_next) + 32'(inflight_next)) < 32'(FIFO_DEPTH);
  end

  always_comb begin
    if (32'(nent) > 32'(PAGE_DEPTH)) total_c = CW'(PAGE_DEPTH);
    else                             total_c = CW'(nent);
  end

  always_ff @(posedge ap_clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= bus.doutb;
      fifo_last[wr_ptr] <= push_last;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state      <= S_IDLE;
      page       <= '0;
      total      <= '0;
      issued     <= '0;
      pushed     <= '0;
      delivered  <= '0;
      enb_q      <= 1'b0;
      addrb_q    <= '0;
      ap_idle_q  <= 1'b1;
      ap_done_q  <= 1'b0;
      tag_sr     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      tag_sr     <= tag_next;
      fifo_count <= count_next;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        pushed <= pushed + 1'b1;
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        delivered <= delivered + 1'b1;
      end
      enb_q     <= 1'b0;
      ap_done_q <= 1'b0;
      ap_idle_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.ap_start) begin
            page  <= bus.bx;
            state <= S_LATCH;
          end else begin
            ap_idle_q <= 1'b1;
          end
        end
        S_LATCH: begin
          total     <= total_c;
          pushed    <= '0;
          delivered <= '0;
          if (total_c == '0) begin
            issued    <= '0;
            ap_done_q <= 1'b1;
            state     <= S_DONE;
          end else begin
            // The buffer is empty here, so the first read needs no credit check.
            enb_q   <= 1'b1;
            addrb_q <= {page, PW'(0)};
            issued  <= CW'(1);
            state   <= (total_c == CW'(1)) ? S_DRAIN : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (issued < total && room) begin
            enb_q   <= 1'b1;
            addrb_q <= {page, issued[PW-1:0]};
            issued  <= issued + 1'b1;
            if (issued + 1'b1 == total) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (delivered + CW'(pop) == total) begin
            ap_done_q <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          ap_idle_q <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          ap_idle_q <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ap_idle    = ap_idle_q;
  assign bus.ap_done    = ap_done_q;
  assign bus.enb        = enb_q;
  assign bus.addrb      = addrb_q;
  assign bus.regceb     = 1'b1;
  assign bus.rstb       = ~ap_rst_n;
  assign bus.dout_valid = !fifo_empty;
  assign bus.dout       = fifo_empty ? '0 : fifo_data[rd_ptr];
  assign bus.dout_last  = !fifo_empty && fifo_last[rd_ptr];
  assign bus.dbg_state  = state;
endmodule
